// File: rtl/seg7_scan_decoder.sv
// Recovers hex nibbles from a scanned, multiplexed, active-low 7-segment bus.
// Patterns must be stable before commit; changes are reported through a one-entry valid/ready buffer.
module seg7_scan_decoder #(
    parameter int DIGITS     = 4,
    parameter int STABLE_CYC = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sample_en,
    input  logic [6:0]            seg_in,
    input  logic [DIGITS-1:0]     an_in,
    output logic [4*DIGITS-1:0]   digit_out,
    output logic [DIGITS-1:0]     digit_valid,
    output logic [DIGITS-1:0]     invalid_err,
    output logic                  upd_valid,
    input  logic                  upd_ready,
    output logic [2:0]            upd_idx,
    output logic [3:0]            upd_nibble,
    output logic                  upd_err,
    output logic                  upd_overrun
);

    localparam logic [3:0] STABLE = 4'(STABLE_CYC);

    // Returns {legal, nibble}; bit order of seg is {g,f,e,d,c,b,a}, active low.
    function automatic logic [4:0] decode(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'b1000000:             r = {1'b1, 4'h0};
            7'b1111001:             r = {1'b1, 4'h1};
            7'b0100100:             r = {1'b1, 4'h2};
            7'b0110000:             r = {1'b1, 4'h3};
            7'b0011001:             r = {1'b1, 4'h4};
            7'b0010010, 7'b0010110: r = {1'b1, 4'h5};
            7'b0000010:             r = {1'b1, 4'h6};
            7'b1111000:             r = {1'b1, 4'h7};
            7'b0000000:             r = {1'b1, 4'h8};
            7'b0010000:             r = {1'b1, 4'h9};
            7'b0001000:             r = {1'b1, 4'hA};
            7'b0000011:             r = {1'b1, 4'hB};
            7'b1000110:             r = {1'b1, 4'hC};
            7'b0100001:             r = {1'b1, 4'hD};
            7'b0000110:             r = {1'b1, 4'hE};
            7'b0001110:             r = {1'b1, 4'hF};
            default:                r = 5'd0;
        endcase
        return r;
    endfunction

    logic [6:0]          last_seg_q, last_seg_d;
    logic [2:0]          last_idx_q, last_idx_d;
    logic [3:0]          count_q, count_d;
    logic [4*DIGITS-1:0] digit_q, digit_d;
    logic [DIGITS-1:0]   dvalid_q, dvalid_d;
    logic [DIGITS-1:0]   derr_q, derr_d;
    logic                upd_valid_q, upd_valid_d;
    logic [2:0]          upd_idx_q, upd_idx_d;
    logic [3:0]          upd_nibble_q, upd_nibble_d;
    logic                upd_err_q, upd_err_d;
    logic                overrun_q, overrun_d;

    logic [3:0] zero_cnt;
    logic [2:0] sel_idx;
    logic       qualify;
    logic       new_pair;
    logic [3:0] base_cnt;
    logic       commit;
    logic [4:0] dec;
    logic [3:0] cur_nib;
    logic       cur_valid;
    logic       cur_err;
    logic       changed;

    always_comb begin
        zero_cnt = 4'd0;
        sel_idx  = 3'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!an_in[i]) begin
                zero_cnt = zero_cnt + 4'd1;
                sel_idx  = 3'(i);
            end
        end
        qualify  = sample_en && (zero_cnt == 4'd1);
        new_pair = (sel_idx != last_idx_q) || (seg_in != last_seg_q);
        // A fresh pair restarts from zero, so STABLE_CYC=1 commits on its first sample.
        base_cnt = new_pair ? 4'd0 : count_q;
        commit   = qualify && (base_cnt < STABLE) && (base_cnt + 4'd1 == STABLE);
        dec      = decode(seg_in);
    end

    always_comb begin
        cur_nib   = 4'd0;
        cur_valid = 1'b0;
        cur_err   = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (sel_idx == 3'(i)) begin
                cur_nib   = digit_q[4*i +: 4];
                cur_valid = dvalid_q[i];
                cur_err   = derr_q[i];
            end
        end
        if (dec[4]) changed = (cur_nib != dec[3:0]) || !cur_valid || cur_err;
        else        changed = cur_valid || !cur_err;
    end

    always_comb begin
        last_seg_d = last_seg_q;
        last_idx_d = last_idx_q;
        count_d    = count_q;
        if (sample_en) begin
            if (!qualify) begin
                count_d = 4'd0;
            end else begin
                if (new_pair) begin
                    last_seg_d = seg_in;
                    last_idx_d = sel_idx;
                end
                count_d = (base_cnt < STABLE) ? base_cnt + 4'd1 : base_cnt;
            end
        end
    end

    always_comb begin
        digit_d  = digit_q;
        dvalid_d = dvalid_q;
        derr_d   = derr_q;
        if (commit) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (sel_idx == 3'(i)) begin
                    if (dec[4]) begin
                        digit_d[4*i +: 4] = dec[3:0];
                        dvalid_d[i]       = 1'b1;
                        derr_d[i]         = 1'b0;
                    end else begin
                        dvalid_d[i] = 1'b0;
                        derr_d[i]   = 1'b1;
                    end
                end
            end
        end
    end

    // Valid/ready: a record transfers on an edge with upd_valid=1 and upd_ready=1;
    // fields hold while valid and not ready, except that a newer record overwrites them.
    always_comb begin
        upd_valid_d  = upd_valid_q;
        upd_idx_d    = upd_idx_q;
        upd_nibble_d = upd_nibble_q;
        upd_err_d    = upd_err_q;
        overrun_d    = overrun_q;
        if (commit && changed) begin
            if (upd_valid_q && !upd_ready) overrun_d = 1'b1;
            upd_valid_d  = 1'b1;
            upd_idx_d    = sel_idx;
            upd_nibble_d = dec[4] ? dec[3:0] : 4'd0;
            upd_err_d    = !dec[4];
        end else if (upd_valid_q && upd_ready) begin
            upd_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_seg_q   <= 7'h7F;
            last_idx_q   <= 3'd0;
            count_q      <= 4'd0;
            digit_q      <= '0;
            dvalid_q     <= '0;
            derr_q       <= '0;
            upd_valid_q  <= 1'b0;
            upd_idx_q    <= 3'd0;
            upd_nibble_q <= 4'd0;
            upd_err_q    <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            last_seg_q   <= last_seg_d;
            last_idx_q   <= last_idx_d;
            count_q      <= count_d;
            digit_q      <= digit_d;
            dvalid_q     <= dvalid_d;
            derr_q       <= derr_d;
            upd_valid_q  <= upd_valid_d;
            upd_idx_q    <= upd_idx_d;
            upd_nibble_q <= upd_nibble_d;
            upd_err_q    <= upd_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign digit_out   = digit_q;
    assign digit_valid = dvalid_q;
    assign invalid_err = derr_q;
    assign upd_valid   = upd_valid_q;
    assign upd_idx     = upd_idx_q;
    assign upd_nibble  = upd_nibble_q;
    assign upd_err     = upd_err_q;
    assign upd_overrun = overrun_q;

endmodule
